// File: rtl/noc_inject_scheduler_if.sv
// ============================================================================
// Module      : noc_inject_scheduler_if
// Description : Requester, mesh-control and status bundle of the injection
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_inject_scheduler_if;
  logic [3:0]  req_valid;
  logic [7:0]  req_dest;
  logic [35:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  processor_ready_signals;
  logic        block_req;
  logic [10:0] p0_configure;
  logic [10:0] p1_configure;
  logic [10:0] p2_configure;
  logic [10:0] p3_configure;
  logic        block_all_paths;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_self;
  logic        err_timeout;

  modport slave (
    input  req_valid, req_dest, req_data, processor_ready_signals, block_req,
    output req_ready, p0_configure, p1_configure, p2_configure, p3_configure,
           block_all_paths, busy, grant_id, err_self, err_timeout
  );

  modport master (
    output req_valid, req_dest, req_data, processor_ready_signals, block_req,
    input  req_ready, p0_configure, p1_configure, p2_configure, p3_configure,
           block_all_paths, busy, grant_id, err_self, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/noc_inject_scheduler.sv
// ============================================================================
// Module      : noc_inject_scheduler
// Description : Round-robin injection scheduler for the 2x2 mesh; holds one
//               configure word at a time and owns the fabric freeze control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_inject_scheduler #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  noc_inject_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRIVE      = 3'd1,
    ST_GAP        = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_BLOCKED    = 3'd4
  } state_t;

  localparam logic [7:0] c_hold_last    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] c_gap_last     = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
  localparam bit         c_skip_gap     = (GAP_CYCLES == 0);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic [7:0]  w_next_cnt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_grant_id;
  logic [10:0] r_word;
  logic        r_err_self;
  logic        r_err_timeout;
  logic        r_block;

  logic [3:0]  w_eligible;
  logic [1:0]  w_winner;
  logic [1:0]  w_sel_dest;
  logic [8:0]  w_sel_data;
  logic        w_accept;
  logic [3:0]  w_req_ready;
  logic        w_self_err;
  logic        w_timeout;

  logic [1:0]  w_dest_arr [4];
  logic [8:0]  w_data_arr [4];
  logic [10:0] w_cfg      [4];

  // Scan from the pointer downwards in reverse so the nearest eligible index wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) rr_pick = idx;
    end
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_dest_arr[g] = bus.req_dest[2*g +: 2];
    assign w_data_arr[g] = bus.req_data[9*g +: 9];
    assign w_cfg[g]      = (r_state == ST_DRIVE && r_grant_id == 2'(g)) ? r_word : 11'd0;
  end

  assign w_eligible = bus.req_valid & bus.processor_ready_signals;
  assign w_winner   = rr_pick(w_eligible, r_rr_ptr);
  assign w_sel_dest = w_dest_arr[w_winner];
  assign w_sel_data = w_data_arr[w_winner];

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_req_ready  = 4'd0;
    w_self_err   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.block_req) begin
          w_next_state = ST_BLOCKED;
        end else if (|w_eligible) begin
          w_accept    = 1'b1;
          w_req_ready = 4'b0001 << w_winner;
          if (w_sel_dest == w_winner) begin
            w_self_err = 1'b1;
          end else begin
            w_next_state = ST_DRIVE;
            w_next_cnt   = 8'd0;
          end
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_hold_last) begin
          w_next_cnt   = 8'd0;
          w_next_state = c_skip_gap ? ST_WAIT_READY : ST_GAP;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_next_cnt   = 8'd0;
          w_next_state = ST_WAIT_READY;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end
      ST_WAIT_READY: begin
        if (bus.processor_ready_signals[r_grant_id]) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == c_timeout_last) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end
      ST_BLOCKED: begin
        if (!bus.block_req) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_rr_ptr      <= 2'd0;
      r_grant_id    <= 2'd0;
      r_word        <= 11'd0;
      r_err_self    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_block       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_err_self    <= w_self_err;
      r_err_timeout <= w_timeout;
      r_block       <= (w_next_state == ST_BLOCKED);
      if (w_accept) begin
        r_grant_id <= w_winner;
        r_rr_ptr   <= w_winner + 2'd1;
        r_word     <= {w_sel_dest, w_sel_data};
      end
    end
  end

  // Configure lanes decode from state so an async reset blanks them at once.
  assign bus.p0_configure    = w_cfg[0];
  assign bus.p1_configure    = w_cfg[1];
  assign bus.p2_configure    = w_cfg[2];
  assign bus.p3_configure    = w_cfg[3];
  assign bus.req_ready       = w_req_ready;
  assign bus.block_all_paths = r_block;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.grant_id        = r_grant_id;
  assign bus.err_self        = r_err_self;
  assign bus.err_timeout     = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_noc_inject_scheduler.sv
// ============================================================================
// Module      : tb_noc_inject_scheduler
// Description : Directed scoreboard bench for noc_inject_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_inject_scheduler;
  localparam int HOLD = 3;
  localparam int GAP  = 1;
  localparam int TMO  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  noc_inject_scheduler_if bus ();

  noc_inject_scheduler #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .TIMEOUT     (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window monitor: pops one expected {port, word} per configure window.
  logic [10:0] m_cfg [4];
  int          m_nz, m_port, m_len;
  bit          m_in_win = 1'b0;
  logic [12:0] m_cur, m_exp;
  always @(negedge clock) begin
    if (reset) begin
      m_in_win = 1'b0;
    end else begin
      m_cfg[0] = bus.p0_configure;
      m_cfg[1] = bus.p1_configure;
      m_cfg[2] = bus.p2_configure;
      m_cfg[3] = bus.p3_configure;
      m_nz = 0;
      m_port = 0;
      for (int i = 0; i < 4; i++) if (m_cfg[i] != 11'd0) begin m_nz++; m_port = i; end
      if (m_nz > 1) check("single_cfg_lane", 32'(m_nz), 32'd1);
      if (m_nz >= 1) begin
        m_cur = {2'(m_port), m_cfg[m_port]};
        if (!m_in_win) begin
          m_in_win = 1'b1;
          m_len = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_window", 32'(m_cur), 32'd0);
          end else begin
            m_exp = exp_q.pop_front();
            check("window_port_word", 32'(m_cur), 32'(m_exp));
          end
        end else begin
          m_len++;
          check("window_stable", 32'(m_cur), 32'(m_exp));
        end
      end else if (m_in_win) begin
        check("window_len", 32'(m_len), 32'(HOLD));
        m_in_win = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] d, input logic [8:0] data);
    bus.req_dest[2*i +: 2] = d;
    bus.req_data[9*i +: 9] = data;
    bus.req_valid[i]       = 1'b1;
  endtask

  task automatic wait_grant(input logic [3:0] exp_ready, input string tag);
    int n = 0;
    #1;
    while (bus.req_ready == 4'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(bus.req_ready), 32'(exp_ready));
  endtask

  task automatic drop_after_edge(input int i);
    @(posedge clock);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.req_valid = 4'd0;
    bus.req_dest  = 8'd0;
    bus.req_data  = 36'd0;
    bus.processor_ready_signals = 4'hF;
    bus.block_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_cfg", 32'(bus.p0_configure | bus.p1_configure | bus.p2_configure | bus.p3_configure), 32'd0);
    check("rst_block", 32'(bus.block_all_paths), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_err", 32'({bus.err_self, bus.err_timeout}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single request from requester 0
    set_req(0, 2'b10, 9'h005);
    wait_grant(4'b0001, "t1_req_ready");
    exp_q.push_back({2'd0, 11'b10000000101});
    drop_after_edge(0);
    @(negedge clock);
    check("t1_p0_word", 32'(bus.p0_configure), 32'(11'b10000000101));
    check("t1_grant", 32'(bus.grant_id), 32'd0);
    repeat (4) @(negedge clock);
    check("t1_busy_wait", 32'(bus.busy), 32'd1);
    @(negedge clock);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // Round robin between requesters 1 and 3, held continuously
    set_req(1, 2'b00, 9'h111);
    set_req(3, 2'b01, 9'h033);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        wait_grant(4'b0010, "t2_grant_1");
        exp_q.push_back({2'd1, 2'b00, 9'h111});
      end else begin
        wait_grant(4'b1000, "t2_grant_3");
        exp_q.push_back({2'd3, 2'b01, 9'h033});
      end
      @(negedge clock);
    end
    bus.req_valid = 4'd0;
    wait_idle("t2_idle");

    // Requester 0 not ready at its router
    bus.processor_ready_signals = 4'b1110;
    set_req(0, 2'b11, 9'h0AA);
    set_req(1, 2'b10, 9'h155);
    wait_grant(4'b0010, "t3_first_1");
    exp_q.push_back({2'd1, 2'b10, 9'h155});
    drop_after_edge(1);
    bus.processor_ready_signals = 4'b1111;
    wait_grant(4'b0001, "t3_then_0");
    exp_q.push_back({2'd0, 2'b11, 9'h0AA});
    drop_after_edge(0);
    wait_idle("t3_idle");

    // Timeout on requester 2
    set_req(2, 2'b00, 9'h0F0);
    wait_grant(4'b0100, "t4_grant_2");
    exp_q.push_back({2'd2, 2'b00, 9'h0F0});
    drop_after_edge(2);
    bus.processor_ready_signals[2] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      check("t4_err_timeout", 32'(bus.err_timeout), 32'(k == 13));
      if (k == 13) check("t4_idle", 32'(bus.busy), 32'd0);
    end
    bus.processor_ready_signals = 4'hF;

    // Self-destination from requester 3
    set_req(3, 2'b11, 9'h1FF);
    wait_grant(4'b1000, "t5_req_ready");
    drop_after_edge(3);
    @(negedge clock);
    check("t5_err_self", 32'(bus.err_self), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_grant", 32'(bus.grant_id), 32'd3);
    @(negedge clock);
    check("t5_err_self_end", 32'(bus.err_self), 32'd0);

    // Block request during requester 0's drive; requester 3 left pending
    set_req(0, 2'b01, 9'h1AB);
    set_req(3, 2'b00, 9'h033);
    wait_grant(4'b0001, "t6_rr_wrap_0");
    exp_q.push_back({2'd0, 2'b01, 9'h1AB});
    drop_after_edge(0);
    bus.block_req = 1'b1;
    @(negedge clock);
    check("t6_block_in_drive", 32'(bus.block_all_paths), 32'd0);
    repeat (5) @(negedge clock);
    check("t6_block_idle", 32'(bus.block_all_paths), 32'd0);
    check("t6_block_priority", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("t6_blocked", 32'(bus.block_all_paths), 32'd1);
      check("t6_no_grant", 32'(bus.req_ready), 32'd0);
    end
    bus.block_req = 1'b0;
    @(negedge clock);
    check("t6_unblock", 32'(bus.block_all_paths), 32'd0);
    check("t6_pending_3", 32'(bus.req_ready), 32'b1000);
    exp_q.push_back({2'd3, 2'b00, 9'h033});
    drop_after_edge(3);
    @(negedge clock);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_cfg", 32'(bus.p0_configure | bus.p1_configure | bus.p2_configure | bus.p3_configure), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
